// File: rtl/tc77_responder.sv
// rtl/tc77_responder.sv - TC77 SPI temperature sensor responder model
// Serves {temp, done, 00} on SIO and commits the 16-bit config write that follows.
module tc77_responder #(
  parameter logic [31:0] CONV_CYCLES = 32'd1000
) (
  input  logic        MCLK,
  input  logic        RESET,
  input  logic        nCS,
  input  logic        SCLK,
  inout  wire         SIO,
  input  logic [12:0] TEMPVALUE,
  output logic [15:0] CONFIG,
  output logic        SHUTDOWN,
  output logic        CONVDONE
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, HOLD} state_t;

  state_t      state;
  logic        ncs_s1, ncs_s2, ncs_d;
  logic        sclk_s1, sclk_s2, sclk_d;
  logic        ncs_fall, ncs_rise, sclk_rise, sclk_fall;
  logic [31:0] conv_cnt;
  logic [12:0] temp_reg;
  logic [14:0] shift;
  logic [15:0] cfg_shift;
  logic [15:0] frame;
  logic [4:0]  bit_cnt;
  logic        sio_oe, sio_out;

  assign SIO = sio_oe ? sio_out : 1'bz;

  // Synchronizers run through reset so a pin already low after reset is not seen as a fall.
  always_ff @(posedge MCLK) begin
    ncs_s1  <= nCS;
    ncs_s2  <= ncs_s1;
    ncs_d   <= ncs_s2;
    sclk_s1 <= SCLK;
    sclk_s2 <= sclk_s1;
    sclk_d  <= sclk_s2;
  end

  assign ncs_fall  = ncs_d & ~ncs_s2;
  assign ncs_rise  = ~ncs_d & ncs_s2;
  assign sclk_rise = ~sclk_d & sclk_s2;
  assign sclk_fall = sclk_d & ~sclk_s2;
  assign frame     = {temp_reg, CONVDONE, 2'b00};

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      conv_cnt <= 32'd0;
      temp_reg <= 13'd0;
      CONVDONE <= 1'b0;
    end else if (SHUTDOWN) begin
      conv_cnt <= 32'd0;
    end else if (conv_cnt == CONV_CYCLES - 32'd1) begin
      conv_cnt <= 32'd0;
      temp_reg <= TEMPVALUE;
      CONVDONE <= 1'b1;
    end else begin
      conv_cnt <= conv_cnt + 32'd1;
    end
  end

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      state     <= IDLE;
      bit_cnt   <= 5'd0;
      shift     <= 15'd0;
      cfg_shift <= 16'd0;
      sio_oe    <= 1'b0;
      sio_out   <= 1'b0;
      CONFIG    <= 16'h0000;
      SHUTDOWN  <= 1'b0;
    end else if (ncs_rise) begin
      state   <= IDLE;
      bit_cnt <= 5'd0;
      sio_oe  <= 1'b0;
      // Only a complete 16-bit write is committed.
      if (state == HOLD) begin
        CONFIG <= cfg_shift;
        if (cfg_shift == 16'hFFFF)
          SHUTDOWN <= 1'b1;
        else if (cfg_shift == 16'h0000)
          SHUTDOWN <= 1'b0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (ncs_fall) begin
            shift   <= frame[14:0];
            sio_out <= frame[15];
            sio_oe  <= 1'b1;
            bit_cnt <= 5'd0;
            state   <= READ;
          end
        end
        READ: begin
          if (sclk_rise) begin
            bit_cnt <= bit_cnt + 5'd1;
          end else if (sclk_fall) begin
            if (bit_cnt == 5'd16) begin
              sio_oe  <= 1'b0;
              bit_cnt <= 5'd0;
              state   <= WRITE;
            end else begin
              sio_out <= shift[14];
              shift   <= {shift[13:0], 1'b0};
            end
          end
        end
        WRITE: begin
          if (sclk_rise) begin
            cfg_shift <= {cfg_shift[14:0], SIO};
            bit_cnt   <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd15)
              state <= HOLD;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tc77_responder.sv
// tb/tb_tc77_responder.sv - directed bench for tc77_responder
// SIO carries a pullup so a released line reads 1.
module tb_tc77_responder;

  localparam int C = 400;
  localparam int H = 5;

  logic        MCLK, RESET, nCS, SCLK;
  wire         SIO;
  logic [12:0] TEMPVALUE;
  logic [15:0] CONFIG;
  logic        SHUTDOWN, CONVDONE;
  logic        tb_oe, tb_val;
  int          checks, failures;
  logic [15:0] w, hi, lo;

  assign SIO = tb_oe ? tb_val : 1'bz;
  pullup (SIO);

  tc77_responder #(.CONV_CYCLES(32'd400)) dut (
    .MCLK(MCLK), .RESET(RESET), .nCS(nCS), .SCLK(SCLK), .SIO(SIO),
    .TEMPVALUE(TEMPVALUE), .CONFIG(CONFIG), .SHUTDOWN(SHUTDOWN), .CONVDONE(CONVDONE)
  );

  initial begin
    MCLK = 1'b0;
    forever #5 MCLK = ~MCLK;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge MCLK);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_frame();
    nCS = 1'b0;
    cyc(4);
  endtask

  task automatic end_frame();
    nCS = 1'b1;
    cyc(4);
  endtask

  task automatic read_bits(input int n, output logic [15:0] v);
    v = 16'h0000;
    for (int i = 0; i < n; i++) begin
      SCLK = 1'b1;
      v = {v[14:0], SIO};
      cyc(H);
      SCLK = 1'b0;
      cyc(H);
    end
  endtask

  task automatic write_bits(input int n, input logic [15:0] v);
    tb_oe = 1'b1;
    for (int i = 0; i < n; i++) begin
      tb_val = v[15-i];
      cyc(H);
      SCLK = 1'b1;
      cyc(H);
      SCLK = 1'b0;
    end
    cyc(H);
    tb_oe = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    RESET = 1'b1;
    nCS = 1'b1;
    SCLK = 1'b0;
    tb_oe = 1'b0;
    tb_val = 1'b0;
    TEMPVALUE = 13'h01B0;
    cyc(5);
    check("reset_sio_released", {15'd0, SIO}, 16'h0001);
    check("reset_config", CONFIG, 16'h0000);
    check("reset_shutdown", {15'd0, SHUTDOWN}, 16'h0000);
    check("reset_convdone", {15'd0, CONVDONE}, 16'h0000);
    RESET = 1'b0;

    start_frame();
    read_bits(16, w);
    check("read_before_conv", w, 16'h0000);
    check("convdone_before_conv", {15'd0, CONVDONE}, 16'h0000);
    end_frame();

    RESET = 1'b1;
    cyc(3);
    RESET = 1'b0;
    cyc(C - 1);
    check("convdone_at_c_minus_1", {15'd0, CONVDONE}, 16'h0000);
    cyc(1);
    check("convdone_at_c", {15'd0, CONVDONE}, 16'h0001);

    start_frame();
    read_bits(16, w);
    check("read_27c", w, 16'h0D84);
    end_frame();

    TEMPVALUE = 13'h1F60;
    cyc(C + 10);
    start_frame();
    read_bits(16, w);
    check("read_minus10c", w, 16'hFB04);
    write_bits(16, 16'hFFFF);
    end_frame();
    check("shutdown_set", {15'd0, SHUTDOWN}, 16'h0001);
    check("config_ffff", CONFIG, 16'hFFFF);

    TEMPVALUE = 13'h0260;
    cyc(2 * C);
    start_frame();
    read_bits(16, w);
    check("read_frozen_in_shutdown", w, 16'hFB04);
    write_bits(16, 16'h0000);
    end_frame();
    check("shutdown_cleared", {15'd0, SHUTDOWN}, 16'h0000);
    check("config_0000", CONFIG, 16'h0000);
    cyc(C + 10);
    start_frame();
    read_bits(16, w);
    check("read_after_wake", w, 16'h1304);
    end_frame();

    start_frame();
    read_bits(8, w);
    check("abort_upper_byte", w, 16'h0013);
    end_frame();
    check("abort_sio_released", {15'd0, SIO}, 16'h0001);
    start_frame();
    read_bits(16, w);
    check("read_after_abort", w, 16'h1304);
    write_bits(10, 16'hA5C3);
    end_frame();
    check("partial_write_discarded", CONFIG, 16'h0000);
    start_frame();
    read_bits(16, w);
    write_bits(16, 16'h1234);
    end_frame();
    check("config_1234", CONFIG, 16'h1234);
    check("mode_unchanged", {15'd0, SHUTDOWN}, 16'h0000);

    start_frame();
    read_bits(5, w);
    check("reset_frame_upper_bits", w, 16'h0002);
    check("sio_driven_bit10", {15'd0, SIO}, 16'h0000);
    RESET = 1'b1;
    cyc(1);
    check("midframe_reset_sio", {15'd0, SIO}, 16'h0001);
    check("midframe_reset_config", CONFIG, 16'h0000);
    check("midframe_reset_shutdown", {15'd0, SHUTDOWN}, 16'h0000);
    check("midframe_reset_convdone", {15'd0, CONVDONE}, 16'h0000);
    cyc(2);
    RESET = 1'b0;
    cyc(10);
    check("frame_not_resumed", {15'd0, SIO}, 16'h0001);
    nCS = 1'b1;
    cyc(4);

    cyc(C + 10);
    TEMPVALUE = 13'h0190;
    start_frame();
    read_bits(8, hi);
    cyc(C + 10);
    read_bits(8, lo);
    check("midframe_old_word", {hi[7:0], lo[7:0]}, 16'h1304);
    end_frame();
    start_frame();
    read_bits(16, w);
    check("next_frame_new_word", w, 16'h0C84);
    end_frame();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tc77_responder.md
# tc77_responder

Cycle-accurate, synthesizable model of the Microchip TC77 SPI temperature sensor that responds to the temperature controller's serial loader (nCS/SIO/CLK) in simulation and on the test fixture. It runs a conversion timer, serves the 16-bit temperature word MSB-first on the bidirectional SIO line, and accepts the 16-bit configuration write that follows the read. The block lets the bench exercise startup-delay and fan-control paths with a programmable temperature, without real silicon.

## Interface

- CONV_CYCLES, 32'd1000 — MCLK cycles per temperature conversion; the first conversion completes this many cycles after reset
- MCLK  in  1  system clock; all logic on posedge
- RESET  in  1  synchronous, active-high reset
- nCS  in  1  chip select from the controller, active low, asynchronous to MCLK
- SCLK  in  1  serial clock from the controller, idle low, asynchronous to MCLK
- SIO  inout  1  serial data; driven only during the read phase, high-Z otherwise
- TEMPVALUE  in  13  temperature to report, two's complement, 0.0625 °C/LSB
- CONFIG  out  16  last committed configuration word
- SHUTDOWN  out  1  high while in shutdown mode (CONFIG == 16'hFFFF)
- CONVDONE  out  1  high once the first conversion has completed

## Operation

- Input sync: 2-flop synchronizer on nCS and SCLK, plus one edge-detect register. MCLK ≥ 8× SCLK is required.
- Conversion timer:
  - 32-bit counter counts to CONV_CYCLES-1 while SHUTDOWN=0, then wraps.
  - On wrap, temp_reg <= TEMPVALUE and CONVDONE <= 1. CONVDONE is sticky until RESET.
  - In shutdown, the counter holds at 0 and temp_reg is frozen.
  - Leaving shutdown restarts the count from 0.
- Frame word is {temp_reg[12:0], CONVDONE, 2'b00}. It is snapshotted into the shift register on the synced nCS fall. Conversions that finish mid-frame update temp_reg only, not the frame in progress.
- FSM:
  - IDLE: SIO high-Z, bit counter 0. On nCS fall: load the shift register, drive bit15, go to READ.
  - READ: each SCLK rise increments the bit counter. Each SCLK fall shifts out the next bit. After the 16th rise, the next SCLK fall releases SIO and the FSM goes to WRITE.
  - WRITE: each SCLK rise samples SIO into cfg_shift, MSB first, and increments the counter. After 16 samples, go to HOLD.
  - HOLD: ignore SCLK and wait for nCS rise.
- nCS rise in any state:
  - SIO goes high-Z and the FSM returns to IDLE.
  - CONFIG <= cfg_shift only if exactly 16 write bits were captured (HOLD). Partial writes are discarded.
- Committed config:
  - 16'hFFFF → SHUTDOWN=1.
  - 16'h0000 → SHUTDOWN=0.
  - Any other value is stored in CONFIG with the mode unchanged.
- Simultaneous synced nCS rise and SCLK edge: nCS wins; the edge is ignored.
- Conversion wrap in the same cycle as a config commit that enters shutdown: the conversion completes (temp_reg updates), then the counter holds.

## Timing

- Reset values:
  - SIO high-Z; CONFIG 16'h0000; SHUTDOWN 0; CONVDONE 0.
  - temp_reg 0; counter 0; FSM IDLE.
- nCS fall at the pins → bit15 driven on SIO within 4 MCLK (2 sync + 1 edge + 1 register).
- SCLK fall → next bit valid on SIO within 4 MCLK, before the controller samples on the following rise.
- nCS rise → SIO high-Z, CONFIG and SHUTDOWN updated, within 4 MCLK.
- First CONVDONE=1: exactly CONV_CYCLES MCLK after the cycle RESET deasserts.
- RESET asserted mid-frame: the FSM returns to IDLE and SIO releases on the next MCLK edge. The frame is not resumed; a new nCS fall is needed.

## Test plan

- Read before first conversion: reset, TEMPVALUE=13'h01B0, immediate 16-bit read → 16'h0000, CONVDONE=0.
- Read after conversion: wait CONV_CYCLES, read → 16'h0D84 (27 °C, done bit set). Set TEMPVALUE=13'h1F60 (−10 °C), wait CONV_CYCLES, read → 16'hFB04.
- Shutdown write:
  - Read, then write 16'hFFFF → SHUTDOWN=1, CONFIG=16'hFFFF.
  - Set TEMPVALUE=13'h0260, wait 2×CONV_CYCLES, read → still 16'hFB04.
  - Write 16'h0000, wait CONV_CYCLES, read → 16'h1304.
- Aborted frames:
  - nCS rise after 8 read bits → SIO high-Z within 4 MCLK; the next frame restarts at bit15 with the full word.
  - Write of only 10 config bits → CONFIG unchanged.
- Mid-frame update: change TEMPVALUE and let a conversion complete while nCS is low → the current frame returns the old word and the next frame returns the new one.
- Reset mid-frame: assert RESET during bit 5 → SIO high-Z next MCLK; all outputs return to reset values.
